// File: rtl/atm_multi_core.sv
// -----------------------------------------------------------------------------
// atm_multi_core
//   Multi-account ATM controller. It serves NUM_ACCT accounts of BAL_W-bit
//   balances and adds PIN authentication with per-account lockout. The confirm
//   button is synchronised and edge-detected. The core also provides an
//   inactivity timeout, abort on card removal and a timed buzzer pulse.
//
//   Optional feature: define ATM_SESSION_LIMIT_EN to add a per-session
//   withdrawal limit (parameter WD_LIMIT).
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-low reset
//   card_present in   card inserted (level)
//   card_id      in   account selected by the inserted card
//   pin_input    in   PIN switches
//   menu_input   in   one-hot menu selection (000 = log out)
//   confirm_btn  in   raw asynchronous confirm button
//   amount       in   deposit / withdraw amount
//   balance      out  balance of the session account, 0 when not authenticated
//   leds         out  [7:0] one-hot state, [9:8] tries, [10] authed
//   seg_value    out  state code for the 7-segment display
//   beep         out  buzzer
//   acct_locked  out  lock flag of the account addressed by card_id
// -----------------------------------------------------------------------------
module atm_multi_core #(
  parameter int BAL_W       = 8,
  parameter int ACCT_IDX_W  = 2,
  parameter int PIN_W       = 4,
  parameter int PIN_BASE    = 5,
  parameter int INIT_BAL    = 100,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int BEEP_CYC    = 50
`ifdef ATM_SESSION_LIMIT_EN
  ,
  parameter int WD_LIMIT    = 200
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  card_present,
  input  logic [ACCT_IDX_W-1:0] card_id,
  input  logic [PIN_W-1:0]      pin_input,
  input  logic [2:0]            menu_input,
  input  logic                  confirm_btn,
  input  logic [BAL_W-1:0]      amount,
  output logic [BAL_W-1:0]      balance,
  output logic [10:0]           leds,
  output logic [3:0]            seg_value,
  output logic                  beep,
  output logic                  acct_locked
);

  localparam int NUM_ACCT = 2**ACCT_IDX_W;
  localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int BEEP_W   = $clog2(BEEP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PIN      = 3'd1,
    S_MENU     = 3'd2,
    S_DEPOSIT  = 3'd3,
    S_WITHDRAW = 3'd4,
    S_SHOW_BAL = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  state_t                  state, state_n;
  logic [ACCT_IDX_W-1:0]   acct, acct_n;
  logic                    authed, authed_n;
  logic [1:0]              tries, tries_n;
  logic [BAL_W-1:0]        bal_q [NUM_ACCT];
  logic [NUM_ACCT-1:0]     lock_q;
  logic [TMO_W-1:0]        tmo_q;
  logic [BEEP_W-1:0]       beep_cnt;
  logic [2:0]              sync_q;

  logic                    evt, tmo_hit;
  logic                    bal_we, lock_set, beep_load;
  logic [BAL_W-1:0]        bal_cur, bal_wd;
  logic [BAL_W:0]          dep_sum;
  logic [PIN_W-1:0]        pin_exp;
  logic [1:0]              tries_inc;
  logic                    limit_hit;
`ifdef ATM_SESSION_LIMIT_EN
  logic [BAL_W:0]          wd_sum;
  logic [BAL_W+1:0]        wd_total;
  logic                    wd_add;
`endif

  // sync_q[0..1] resolve metastability, sync_q[2] is the delay flop for the
  // rising-edge detect, so a held button produces exactly one event.
  assign evt       = sync_q[1] & ~sync_q[2];
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign bal_cur   = bal_q[acct];
  assign dep_sum   = {1'b0, bal_cur} + {1'b0, amount};
  assign pin_exp   = PIN_W'(PIN_BASE) + PIN_W'(acct);
  assign tries_inc = tries + 2'd1;

`ifdef ATM_SESSION_LIMIT_EN
  assign wd_total  = {1'b0, wd_sum} + {2'b00, amount};
  assign limit_hit = (wd_total > (BAL_W+2)'(WD_LIMIT));
`else
  assign limit_hit = 1'b0;
`endif

  // NOTE: every signal driven here gets a default before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    acct_n    = acct;
    authed_n  = authed;
    tries_n   = tries;
    bal_we    = 1'b0;
    bal_wd    = bal_cur;
    lock_set  = 1'b0;
    beep_load = 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
    wd_add    = 1'b0;
`endif

    if (state != S_IDLE && (!card_present || tmo_hit)) begin
      // Card removal and timeout both abort the session and drop any
      // pending transaction; removal is tested first by construction.
      state_n  = S_IDLE;
      authed_n = 1'b0;
      tries_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (card_present && !lock_q[card_id]) begin
            acct_n  = card_id;
            state_n = S_PIN;
          end
        end
        S_PIN: begin
          if (evt) begin
            if (pin_input == pin_exp) begin
              tries_n  = '0;
              authed_n = 1'b1;
              state_n  = S_MENU;
            end else if (tries_inc == 2'(MAX_TRIES)) begin
              lock_set  = 1'b1;
              tries_n   = '0;
              authed_n  = 1'b0;
              state_n   = S_ERROR;
              beep_load = 1'b1;
            end else begin
              tries_n   = tries_inc;
              beep_load = 1'b1;
            end
          end
        end
        S_MENU: begin
          if (evt) begin
            case (menu_input)
              3'b001:  state_n = S_DEPOSIT;
              3'b010:  state_n = S_WITHDRAW;
              3'b100:  state_n = S_SHOW_BAL;
              3'b000: begin
                state_n  = S_IDLE;
                authed_n = 1'b0;
              end
              default: beep_load = 1'b1;
            endcase
          end
        end
        S_DEPOSIT: begin
          if (evt) begin
            beep_load = 1'b1;
            if (dep_sum[BAL_W]) begin
              state_n = S_ERROR;
            end else begin
              bal_we  = 1'b1;
              bal_wd  = dep_sum[BAL_W-1:0];
              state_n = S_DONE;
            end
          end
        end
        S_WITHDRAW: begin
          if (evt) begin
            beep_load = 1'b1;
            if (amount > bal_cur || limit_hit) begin
              state_n = S_ERROR;
            end else begin
              bal_we  = 1'b1;
              bal_wd  = bal_cur - amount;
              state_n = S_DONE;
`ifdef ATM_SESSION_LIMIT_EN
              wd_add  = 1'b1;
`endif
            end
          end
        end
        S_SHOW_BAL, S_DONE, S_ERROR: begin
          if (evt) state_n = authed ? S_MENU : S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      acct     <= '0;
      authed   <= 1'b0;
      tries    <= '0;
      lock_q   <= '0;
      tmo_q    <= '0;
      beep_cnt <= '0;
      sync_q   <= '0;
      // NOTE: the balance array is architectural state with a defined
      // post-reset value, so it is reset like any other register here.
      for (int i = 0; i < NUM_ACCT; i++) bal_q[i] <= BAL_W'(INIT_BAL);
`ifdef ATM_SESSION_LIMIT_EN
      wd_sum   <= '0;
`endif
    end else begin
      state  <= state_n;
      acct   <= acct_n;
      authed <= authed_n;
      tries  <= tries_n;
      sync_q <= {sync_q[1:0], confirm_btn};

      if (bal_we)   bal_q[acct]  <= bal_wd;
      if (lock_set) lock_q[acct] <= 1'b1;

      if (state == S_IDLE || evt || tmo_hit) tmo_q <= '0;
      else                                   tmo_q <= tmo_q + 1'b1;

      if (beep_load)          beep_cnt <= BEEP_W'(BEEP_CYC);
      else if (beep_cnt != 0) beep_cnt <= beep_cnt - 1'b1;

`ifdef ATM_SESSION_LIMIT_EN
      if (state == S_IDLE) wd_sum <= '0;
      else if (wd_add)     wd_sum <= wd_sum + {1'b0, amount};
`endif
    end
  end

  assign balance     = authed ? bal_cur : '0;
  assign leds        = {authed, tries, 8'b1 << state};
  assign seg_value   = {1'b0, state};
  assign beep        = (beep_cnt != 0);
  assign acct_locked = lock_q[card_id];

endmodule

// File: doc/atm_multi_core.md
Name: atm_multi_core

Overview:
- Parametrised successor to the single-account ATM FSM plus board wrapper.
- Serves NUM_ACCT accounts of BAL_W-bit balances.
- Adds PIN authentication with per-account lockout, a synchronised confirm-button edge detector, an inactivity timeout, card-removal abort and a timed buzzer pulse.
- Sits directly under the board top; drives the balance display, LEDs, 7-seg code and buzzer.

Parameters:
- BAL_W, 8: balance and amount width in bits.
- ACCT_IDX_W, 2: account index width; NUM_ACCT = 2**ACCT_IDX_W.
- PIN_W, 4: PIN width.
- PIN_BASE, 5: PIN of account i = (PIN_BASE + i) mod 2**PIN_W.
- INIT_BAL, 100: balance of every account after reset.
- MAX_TRIES, 3: wrong PINs before the account locks (range 1..3).
- TIMEOUT_CYC, 1000: inactivity cycles before session abort.
- BEEP_CYC, 50: buzzer pulse length in cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- card_present  in  1  card inserted (level).
- card_id  in  ACCT_IDX_W  account selected by the inserted card.
- pin_input  in  PIN_W  PIN switches.
- menu_input  in  3  one-hot menu selection.
- confirm_btn  in  1  raw, asynchronous confirm button.
- amount  in  BAL_W  deposit/withdraw amount.
- balance  out  BAL_W  current account balance; 0 when not authenticated.
- leds  out  11  status LEDs.
- seg_value  out  4  state code.
- beep  out  1  buzzer.
- acct_locked  out  1  lock flag of card_id.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; all balances=INIT_BAL; all lock flags=0; tries=0.
  - Timeout and beep counters = 0; sync flops = 0.
  - Outputs: balance=0, leds=11'b00000000001, seg_value=0, beep=0, acct_locked=0.
  - Reset mid-transaction discards that transaction.
- Confirm event: confirm_btn passes 2 sync flops plus a delay flop; evt = s2 & ~s3.
  - A press first sampled high at edge k acts at edge k+2.
  - Exactly one evt per press, regardless of hold length.
- States and seg_value codes: IDLE 0, PIN 1, MENU 2, DEPOSIT 3, WITHDRAW 4, SHOW_BAL 5, DONE 6, ERROR 7.
- IDLE: on card_present=1 and lock[card_id]=0, latch acct=card_id, go to PIN. A locked card stays in IDLE.
- PIN, on evt:
  - pin_input matches: tries=0, authed=1, go to MENU.
  - Mismatch: tries+1. If tries reaches MAX_TRIES, set lock[acct], tries=0, go to ERROR (authed=0). Otherwise stay in PIN and pulse beep.
- MENU, on evt:
  - 001 goes to DEPOSIT; 010 goes to WITHDRAW; 100 goes to SHOW_BAL.
  - 000 logs out: IDLE, authed=0.
  - Any other code stays in MENU and pulses beep.
- DEPOSIT, on evt:
  - If bal+amount overflows BAL_W (carry out), go to ERROR with balance unchanged.
  - Otherwise bal+=amount and go to DONE.
- WITHDRAW, on evt:
  - amount>bal goes to ERROR.
  - Otherwise bal-=amount and go to DONE. amount=0 is legal (no-op DONE).
- SHOW_BAL, DONE, ERROR, on evt:
  - Go to MENU if authed, else IDLE.
- Balance updates are committed in the same edge as the state transition.
- Entering DONE or ERROR loads the beep counter with BEEP_CYC; beep=1 while counter≠0.
  - A new trigger reloads the counter. Wrong-PIN and invalid-menu beeps use the same pulse.
- Timeout:
  - The counter clears on every evt and in IDLE.
  - In any other state, counter reaching TIMEOUT_CYC-1 forces IDLE with authed=0 and tries=0.
  - Any pending transaction is discarded.
- Card removal: card_present=0 in any non-IDLE state forces IDLE on the next edge; this takes priority over evt in the same cycle.
- Priority order: reset > card removal > timeout > evt.
- leds mapping:
  - [7:0] one-hot state.
  - [9:8] tries.
  - [10] authed.
- balance = authed ? bal[acct] : 0.
- acct_locked = lock[card_id] (combinational).

Optional Feature:
- Macro: ATM_SESSION_LIMIT_EN.
- Defined:
  - Adds parameter WD_LIMIT (default 200) and a BAL_W+1-bit session withdrawal sum, cleared when the session ends.
  - A withdraw whose amount+sum exceeds WD_LIMIT goes to ERROR with balance unchanged.
  - A successful withdraw adds amount to the sum.
- Undefined: no limit logic; withdrawals are bounded only by balance.

Test Plan:
- Login and deposit: reset; card_id=2; PIN=7, evt; menu 001, evt; amount=20, evt.
  - Expect DONE (seg 6), balance=120, beep high for exactly 50 cycles.
- Lockout: card_id=1; wrong PIN with 3 evts.
  - Expect tries 1, 2, then ERROR with acct_locked=1.
  - After evt: IDLE. Reinsert card 1: stays IDLE.
- Overdraw and overflow:
  - From bal=100, withdraw 101 gives ERROR with balance 100.
  - Deposit 156 gives ERROR with balance 100; deposit 155 gives DONE with balance 255.
- Button hold: confirm held 40 cycles in MENU with 100.
  - Exactly one transition, to SHOW_BAL, at edge k+2.
- Timeout and removal:
  - Idle 999 cycles in MENU gives IDLE with balance=0.
  - card_present dropped in WITHDRAW while evt is in the same cycle gives IDLE with balance unchanged.
- Session limit (ATM_SESSION_LIMIT_EN, WD_LIMIT=200, bal=255):
  - Withdraw 150 gives DONE.
  - Withdraw 60 gives ERROR.
  - Logout, re-login, withdraw 60 gives DONE.
